seq_operand_streamer: RTL and testbench

- Transmit-side counterpart to the sequenced accumulators in this design.
- On a rising edge of a trigger, captures COUNT parallel operands and emits them one per cycle on a valid/ready stream: operand 0 first, first/last markers.
- The downstream receiver sums or stores the beats.
- Also reports the wrap-around sum of the emitted beats, so producer and consumer results can be cross-checked.

---
 rtl/seq_operand_streamer_pkg.sv | 7 +
 rtl/seq_operand_streamer_if.sv | 10 +
 rtl/rising_edge_detect.sv | 12 +
 rtl/seq_operand_streamer.sv | 75 +++++++
 tb/tb_seq_operand_streamer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/seq_operand_streamer_pkg.sv
// seq_operand_streamer_pkg: shared state encoding and index-width helper
package seq_operand_streamer_pkg;
  typedef enum logic {ST_IDLE, ST_SEND} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_operand_streamer_if.sv
// seq_operand_streamer_if: valid/ready beat stream with first/last markers
interface seq_operand_streamer_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_first;
  logic out_last;
  modport master(output out_data, out_valid, out_first, out_last, input out_ready);
  modport slave(input out_data, out_valid, out_first, out_last, output out_ready);
endinterface

// File: rtl/rising_edge_detect.sv
// rising_edge_detect: one-cycle pulse on a 0->1 transition, reset value of the delayed copy selectable
module rising_edge_detect #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);
  logic in_q;
  always_ff @(posedge clk)
    in_q <= reset ? RST_VAL : in;
  assign rise = in & ~in_q;
endmodule

// File: rtl/seq_operand_streamer.sv
// seq_operand_streamer: captures COUNT operands on a trigger rise and streams them one per beat
module seq_operand_streamer
  import seq_operand_streamer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int COUNT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger,
  input  logic [COUNT*WIDTH-1:0] operands,
  seq_operand_streamer_if.master s,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       sum_out,
  output logic                   overrun
);
  localparam int IW = idx_w(COUNT);
  state_t state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] beat;
  logic [COUNT-1:0][WIDTH-1:0] shadow;
  logic rise;
  logic is_last;
  logic xfer;
  rising_edge_detect #(.RST_VAL(1'b1)) u_red (
    .clk  (clk),
    .reset(reset),
    .in   (trigger),
    .rise (rise)
  );
  assign beat = shadow[idx];
  assign is_last = idx == IW'(COUNT - 1);
  assign busy = state == ST_SEND;
  assign xfer = busy & s.out_ready;
  assign s.out_valid = busy;
  assign s.out_data = busy ? beat : '0;
  assign s.out_first = busy & (idx == '0);
  assign s.out_last = busy & is_last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      acc     <= '0;
      shadow  <= '0;
      sum_out <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (rise) begin
          shadow <= operands;
          idx    <= '0;
          acc    <= '0;
          state  <= ST_SEND;
        end
      end else begin
        if (rise) overrun <= 1'b1;
        if (xfer) begin
          acc <= acc + beat;
          if (is_last) begin
            sum_out <= acc + beat;
            state   <= ST_IDLE;
            done    <= 1'b1;
            idx     <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_operand_streamer.sv
// tb_seq_operand_streamer: directed vectors with hand-computed beats and sums
module tb_seq_operand_streamer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trigger = 1'b0;
  logic [47:0] operands = '0;
  logic busy, done, overrun;
  logic [15:0] sum_out;
  int errs = 0;
  int checks = 0;
  seq_operand_streamer_if #(.WIDTH(16)) s ();
  seq_operand_streamer #(.WIDTH(16), .COUNT(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .operands(operands),
    .s       (s),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .overrun (overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_beat(input string tag, input logic [15:0] d, input logic f, input logic l);
    chk(tag, {13'd0, s.out_valid, s.out_first, s.out_last, s.out_data, busy},
        {13'd0, 1'b1, f, l, d, 1'b1});
  endtask
  task automatic chk_idle(input string tag, input logic dn, input logic [15:0] sm);
    chk(tag, {12'd0, s.out_valid, s.out_first, s.out_last, busy, done, sum_out},
        {12'd0, 1'b0, 1'b0, 1'b0, 1'b0, dn, sm});
  endtask
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    trigger = 1'b0;
    step();
    operands = {c, b, a};
    trigger = 1'b1;
    step();
  endtask
  initial begin
    s.out_ready = 1'b1;
    step();
    step();
    chk_idle("reset_outputs", 1'b0, 16'h0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    step();
    chk_idle("post_reset_idle", 1'b0, 16'h0);
    start(16'd3, 16'd5, 16'd7);
    chk_beat("basic_b0", 16'd3, 1'b1, 1'b0);
    step();
    chk_beat("basic_b1", 16'd5, 1'b0, 1'b0);
    step();
    chk_beat("basic_b2", 16'd7, 1'b0, 1'b1);
    step();
    chk_idle("basic_done", 1'b1, 16'd15);
    step();
    chk_idle("basic_done_once", 1'b0, 16'd15);
    start(16'h1111, 16'h2222, 16'h3333);
    chk_beat("bp_b0", 16'h1111, 1'b1, 1'b0);
    step();
    chk_beat("bp_b1", 16'h2222, 1'b0, 1'b0);
    s.out_ready = 1'b0;
    step();
    chk_beat("bp_hold1", 16'h2222, 1'b0, 1'b0);
    step();
    chk_beat("bp_hold2", 16'h2222, 1'b0, 1'b0);
    s.out_ready = 1'b1;
    step();
    chk_beat("bp_b2", 16'h3333, 1'b0, 1'b1);
    step();
    chk_idle("bp_done", 1'b1, 16'h6666);
    start(16'hFFFF, 16'h0002, 16'h0001);
    chk_beat("wrap_b0", 16'hFFFF, 1'b1, 1'b0);
    step();
    chk_beat("wrap_b1", 16'h0002, 1'b0, 1'b0);
    step();
    chk_beat("wrap_b2", 16'h0001, 1'b0, 1'b1);
    step();
    chk_idle("wrap_done", 1'b1, 16'h0002);
    start(16'd10, 16'd20, 16'd30);
    chk_beat("ovr_b0", 16'd10, 1'b1, 1'b0);
    trigger = 1'b0;
    step();
    chk_beat("ovr_b1", 16'd20, 1'b0, 1'b0);
    trigger = 1'b1;
    step();
    chk_beat("ovr_b2", 16'd30, 1'b0, 1'b1);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    s.out_ready = 1'b0;
    trigger = 1'b0;
    step();
    chk_beat("ovr_b2_hold", 16'd30, 1'b0, 1'b1);
    s.out_ready = 1'b1;
    trigger = 1'b1;
    step();
    chk_idle("ovr_done", 1'b1, 16'd60);
    trigger = 1'b0;
    step();
    chk_idle("ovr_no_second", 1'b0, 16'd60);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    start(16'd1, 16'd2, 16'd3);
    chk_beat("b2b_b0", 16'd1, 1'b1, 1'b0);
    trigger = 1'b0;
    step();
    step();
    chk_beat("b2b_b2", 16'd3, 1'b0, 1'b1);
    step();
    chk_idle("b2b_done", 1'b1, 16'd6);
    operands = {16'd9, 16'd8, 16'd100};
    trigger = 1'b1;
    step();
    chk_beat("b2b_restart", 16'd100, 1'b1, 1'b0);
    step();
    step();
    step();
    chk_idle("b2b_done2", 1'b1, 16'd117);
    chk("b2b_sticky", {31'd0, overrun}, 32'd1);
    start(16'd4, 16'd5, 16'd6);
    chk_beat("rst_b0", 16'd4, 1'b1, 1'b0);
    step();
    chk_beat("rst_b1", 16'd5, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk_idle("rst_cleared", 1'b0, 16'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    step();
    chk_idle("rst_held_trig", 1'b0, 16'd0);
    step();
    chk_idle("rst_held_trig2", 1'b0, 16'd0);
    start(16'd4, 16'd5, 16'd6);
    chk_beat("rst_fresh_b0", 16'd4, 1'b1, 1'b0);
    step();
    step();
    step();
    chk_idle("rst_fresh_done", 1'b1, 16'd15);
    start(16'd7, 16'd8, 16'd9);
    operands = {16'hAAAA, 16'hBBBB, 16'hCCCC};
    chk_beat("cap_b0", 16'd7, 1'b1, 1'b0);
    step();
    chk_beat("cap_b1", 16'd8, 1'b0, 1'b0);
    step();
    chk_beat("cap_b2", 16'd9, 1'b0, 1'b1);
    step();
    chk_idle("cap_done", 1'b1, 16'd24);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
